vmem_arbiter: RTL and testbench
===============================

Name: vmem_arbiter

Overview:
- Arbitrates a single asynchronous SRAM between three requesters and sequences each SRAM access cycle.
- Port 0 is the video scan-out fetch. It has fixed priority, protected by a starvation guard.
- Ports 1 and 2 are general (CPU, blitter). They share the remaining bandwidth round-robin.
- Sits between the video/CPU datapaths and the physical SRAM pins; replaces static time-slot scheduling with demand-driven access.

Parameters:
AWIDTH, 19, address width
DWIDTH, 8, data width
ACC_CYCLES, 2, strobe-low cycles per access (1..7)
MAX_VBURST, 4, max consecutive video grants while a general port waits (1..15)

Ports:
MemClk  in  1  memory clock; all logic on posedge
MemResetN  in  1  asynchronous, active-low reset
ReqN[0..2]  in  1 each  request level, one per port (Req0, Req1, Req2)
AddrN[0..2]  in  AWIDTH each  request address
WriteN[0..2]  in  1 each  1 = write, 0 = read
WDataN[0..2]  in  DWIDTH each  write data
AckN[0..2]  out  1 each  one-cycle completion pulse
RData  out  DWIDTH  read data, shared; valid in the Ack cycle of a read
MemAddrPort  out  AWIDTH  SRAM address
MemDataPort  inout  DWIDTH  SRAM data bus
MemWriteEnableN  out  1  SRAM WE#, active low
MemOutputEnableN  out  1  SRAM OE#, active low

Behaviour:
- Reset values (asynchronous, immediate on MemResetN=0):
  - state IDLE; all Ack=0; RData=0; MemAddrPort=0
  - MemWriteEnableN=1, MemOutputEnableN=1; MemDataPort high-Z
  - RR pointer=port1; VBurst counter=0
- Reset mid-access: strobes deassert and the bus tristates immediately. No Ack is issued; the transaction is lost.
- FSM states: IDLE -> SETUP (1 cycle) -> ACCESS (ACC_CYCLES cycles) -> HOLD (1 cycle) -> IDLE.
- IDLE:
  - If any Req is high, select a winner (rules below).
  - Latch its Addr, Write, WData and port id; go to SETUP.
  - Otherwise stay in IDLE.
- SETUP: MemAddrPort = latched address; both strobes high. For a write, drive MemDataPort = latched WData.
- ACCESS:
  - Read: OE#=0, bus high-Z.
  - Write: WE#=0, bus driven.
  - Cycle counter runs 0..ACC_CYCLES-1.
  - On the final ACCESS edge of a read, capture MemDataPort into RData.
- HOLD:
  - Strobes high; address held.
  - Write data stays driven through HOLD, then the bus is released in IDLE.
  - Ack of the owning port = 1 for exactly this cycle. RData stays stable until the next read capture.
- Latency: Req seen high in IDLE at cycle 0 -> Ack high in cycle 2+ACC_CYCLES (cycle 4 at default). Total access = 3+ACC_CYCLES cycles, no idle gap required.
- Requester rules:
  - Hold Addr/Write/WData stable from Req assertion until Ack.
  - Request fields are latched at grant, so changes after grant are ignored.
  - Deasserting Req before Ack does not abort the access; Ack is still pulsed.
  - Keeping Req high through the Ack cycle issues a new request, arbitrated in the following IDLE.
- Arbitration (evaluated in IDLE only):
  - Video (port 0) wins if Req0=1, unless VBurst==MAX_VBURST and Req1|Req2.
  - Otherwise a general port wins. If both are pending, the RR pointer decides; if one is pending, it wins.
  - After a general grant, the RR pointer moves to the other general port.
- VBurst counter:
  - Increments on a video grant while Req1|Req2=1, saturating at MAX_VBURST.
  - Clears on any general grant, or in IDLE when Req1=Req2=0.
- Bus contention: MemDataPort is never driven while OE#=0. WE# and OE# are never low simultaneously.
- Only the owning port's Ack may pulse; at most one Ack is high per cycle.

Test Plan:
1. Reset release, Req0=1 read at Addr0=0x12345, SRAM model returns 0xA5 -> MemAddrPort=0x12345 from cycle 1; OE# low in cycles 2-3; Ack0=1 in cycle 4 with RData=0xA5; WE# stays 1.
2. Req1 write Addr1=0x00010, WData1=0x3C -> WE# low cycles 2-3; bus=0x3C cycles 1-4, high-Z after; Ack1 cycle 4; SRAM model holds 0x3C.
3. Req1 and Req2 held high continuously, Req0=0 -> grants alternate 1,2,1,2; Ack spacing 5 cycles; no Ack0.
4. Req0 and Req1 held high continuously, MAX_VBURST=4 -> grant sequence 0,0,0,0,1,0,0,0,0,1...; VBurst clears after each port-1 grant.
5. MemResetN pulsed low during ACCESS of a write -> WE#/OE# go 1 and bus high-Z without waiting for a clock edge; no Ack; next Req served normally from IDLE.
6. Req2 dropped one cycle after grant; Addr2 changed mid-access -> access completes at the originally latched address; Ack2 still pulses; no further Req2 grant.

Source files
------------

// File: rtl/vmem_arbiter.sv
// vmem_arbiter: shares one asynchronous SRAM between three requesters and
// sequences every access as IDLE -> SETUP -> ACCESS (ACC_CYCLES) -> HOLD.
//   MemClk, MemResetN       clock (posedge) and async active-low reset
//   Req/Addr/Write/WData0-2 request level and fields; port 0 is video scan-out
//   Ack0-2                  one-cycle completion pulse of the owning port
//   RData                   read data, valid in the Ack cycle of a read, then held
//   MemAddrPort             SRAM address
//   MemDataPort             SRAM data bus (driven only for writes)
//   MemWriteEnableN         SRAM WE#, active low
//   MemOutputEnableN        SRAM OE#, active low
module vmem_arbiter #(
    parameter int unsigned AWIDTH     = 19,
    parameter int unsigned DWIDTH     = 8,
    parameter int unsigned ACC_CYCLES = 2,
    parameter int unsigned MAX_VBURST = 4
) (
    input  logic              MemClk,
    input  logic              MemResetN,
    input  logic              Req0,
    input  logic              Req1,
    input  logic              Req2,
    input  logic [AWIDTH-1:0] Addr0,
    input  logic [AWIDTH-1:0] Addr1,
    input  logic [AWIDTH-1:0] Addr2,
    input  logic              Write0,
    input  logic              Write1,
    input  logic              Write2,
    input  logic [DWIDTH-1:0] WData0,
    input  logic [DWIDTH-1:0] WData1,
    input  logic [DWIDTH-1:0] WData2,
    output logic              Ack0,
    output logic              Ack1,
    output logic              Ack2,
    output logic [DWIDTH-1:0] RData,
    output logic [AWIDTH-1:0] MemAddrPort,
    inout  wire  [DWIDTH-1:0] MemDataPort,
    output logic              MemWriteEnableN,
    output logic              MemOutputEnableN
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned VB_W  = 4;
    localparam int unsigned PID_W = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AWIDTH-1:0]  lat_addr_q, lat_addr_d;
    logic               lat_wr_q, lat_wr_d;
    logic [DWIDTH-1:0]  lat_wdata_q, lat_wdata_d;
    logic [PID_W-1:0]   lat_port_q, lat_port_d;
    logic               rr_q, rr_d;          // 1: port 2 wins the next general tie
    logic [VB_W-1:0]    vb_q, vb_d;
    logic [2:0]         ack_q, ack_d;
    logic [DWIDTH-1:0]  rdata_q, rdata_d;
    logic [AWIDTH-1:0]  addr_q, addr_d;
    logic               we_n_q, we_n_d;
    logic               oe_n_q, oe_n_d;
    logic               drv_q, drv_d;

    logic               gen_pend;
    logic               vid_block;
    logic               gnt_valid;
    logic [PID_W-1:0]   gnt_port;
    logic [AWIDTH-1:0]  gnt_addr;
    logic               gnt_wr;
    logic [DWIDTH-1:0]  gnt_wdata;

    // Winner selection; only consumed while IDLE
    always_comb begin
        gen_pend  = Req1 | Req2;
        vid_block = (vb_q == VB_W'(MAX_VBURST)) && gen_pend;
        gnt_valid = Req0 | gen_pend;
        gnt_port  = PID_W'(0);
        if (Req0 && !vid_block) begin
            gnt_port = PID_W'(0);
        end else if (Req1 && Req2) begin
            gnt_port = rr_q ? PID_W'(2) : PID_W'(1);
        end else if (Req1) begin
            gnt_port = PID_W'(1);
        end else if (Req2) begin
            gnt_port = PID_W'(2);
        end
        case (gnt_port)
            PID_W'(1): begin
                gnt_addr  = Addr1;
                gnt_wr    = Write1;
                gnt_wdata = WData1;
            end
            PID_W'(2): begin
                gnt_addr  = Addr2;
                gnt_wr    = Write2;
                gnt_wdata = WData2;
            end
            default: begin
                gnt_addr  = Addr0;
                gnt_wr    = Write0;
                gnt_wdata = WData0;
            end
        endcase
    end

    // Next-state and next-output logic; pin values are registered below
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_addr_d  = lat_addr_q;
        lat_wr_d    = lat_wr_q;
        lat_wdata_d = lat_wdata_q;
        lat_port_d  = lat_port_q;
        rr_d        = rr_q;
        vb_d        = vb_q;
        ack_d       = 3'b000;
        rdata_d     = rdata_q;
        addr_d      = addr_q;
        we_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        drv_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!gen_pend) begin
                    vb_d = '0;
                end
                if (gnt_valid) begin
                    state_d     = S_SETUP;
                    lat_addr_d  = gnt_addr;
                    lat_wr_d    = gnt_wr;
                    lat_wdata_d = gnt_wdata;
                    lat_port_d  = gnt_port;
                    addr_d      = gnt_addr;
                    drv_d       = gnt_wr;
                    if (gnt_port == PID_W'(0)) begin
                        if (gen_pend && (vb_q != VB_W'(MAX_VBURST))) begin
                            vb_d = vb_q + VB_W'(1);
                        end
                    end else begin
                        vb_d = '0;
                        rr_d = (gnt_port == PID_W'(1));
                    end
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = '0;
                we_n_d  = ~lat_wr_q;
                oe_n_d  = lat_wr_q;
                drv_d   = lat_wr_q;
            end
            S_ACCESS: begin
                drv_d = lat_wr_q;
                if (cnt_q == CNT_W'(ACC_CYCLES - 1)) begin
                    state_d = S_HOLD;
                    ack_d   = 3'b001 << lat_port_q;
                    if (!lat_wr_q) begin
                        rdata_d = MemDataPort;
                    end
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    we_n_d = ~lat_wr_q;
                    oe_n_d = lat_wr_q;
                end
            end
            S_HOLD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge MemClk or negedge MemResetN) begin
        if (!MemResetN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and pin registers; reset releases the bus and strobes at once
    always_ff @(posedge MemClk or negedge MemResetN) begin
        if (!MemResetN) begin
            cnt_q       <= '0;
            lat_addr_q  <= '0;
            lat_wr_q    <= 1'b0;
            lat_wdata_q <= '0;
            lat_port_q  <= '0;
            rr_q        <= 1'b0;
            vb_q        <= '0;
            ack_q       <= 3'b000;
            rdata_q     <= '0;
            addr_q      <= '0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            drv_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            lat_addr_q  <= lat_addr_d;
            lat_wr_q    <= lat_wr_d;
            lat_wdata_q <= lat_wdata_d;
            lat_port_q  <= lat_port_d;
            rr_q        <= rr_d;
            vb_q        <= vb_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            addr_q      <= addr_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            drv_q       <= drv_d;
        end
    end

    assign Ack0             = ack_q[0];
    assign Ack1             = ack_q[1];
    assign Ack2             = ack_q[2];
    assign RData            = rdata_q;
    assign MemAddrPort      = addr_q;
    assign MemWriteEnableN  = we_n_q;
    assign MemOutputEnableN = oe_n_q;
    assign MemDataPort      = drv_q ? lat_wdata_q : {DWIDTH{1'bz}};

endmodule

// File: tb/tb_vmem_arbiter.sv
// Testbench for vmem_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_vmem_arbiter;

    localparam int ACC  = 2;
    localparam int MAXV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req [3];
    logic [18:0] addr [3];
    logic        wr [3];
    logic [7:0]  wd [3];
    logic        ack0, ack1, ack2;
    logic [7:0]  rdata;
    logic [18:0] mem_addr;
    wire  [7:0]  mem_data;
    logic        we_n, oe_n;

    vmem_arbiter dut (
        .MemClk(clk), .MemResetN(rst_n),
        .Req0(req[0]), .Req1(req[1]), .Req2(req[2]),
        .Addr0(addr[0]), .Addr1(addr[1]), .Addr2(addr[2]),
        .Write0(wr[0]), .Write1(wr[1]), .Write2(wr[2]),
        .WData0(wd[0]), .WData1(wd[1]), .WData2(wd[2]),
        .Ack0(ack0), .Ack1(ack1), .Ack2(ack2),
        .RData(rdata), .MemAddrPort(mem_addr), .MemDataPort(mem_data),
        .MemWriteEnableN(we_n), .MemOutputEnableN(oe_n)
    );

    always #5 clk = ~clk;

    // SRAM model: drives the bus while OE# is low, commits writes on WE# rising
    logic [7:0] sram [logic [18:0]];
    logic [7:0] sram_q;
    assign mem_data = (!oe_n) ? sram_q : 8'hzz;

    function automatic logic [7:0] mem_init(input logic [18:0] a);
        return 8'(a[7:0] ^ a[15:8] ^ 8'h5A);
    endfunction

    always @* begin
        if (sram.exists(mem_addr)) sram_q = sram[mem_addr];
        else sram_q = mem_init(mem_addr);
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic chk_undriven(input string nm);
        total++;
        if (!((mem_data === 8'hzz) || (mem_data === 8'h00))) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: bus got %0h expected released (t=%0t)", nm, mem_data, $time);
        end
    endtask

    // Reference model state
    logic [7:0]  m_mem [logic [18:0]];
    int          cyc;
    bit          m_act;
    int          m_g, m_port;
    bit          m_wr;
    logic [18:0] m_ta;
    logic [7:0]  m_twd, m_trd;
    logic [18:0] m_last_addr;
    logic [7:0]  m_last_rd;
    int          m_rr, m_vb;
    int          ack_cyc [$];
    int          ack_port [$];

    function automatic logic [7:0] m_read(input logic [18:0] a);
        if (m_mem.exists(a)) return m_mem[a];
        return mem_init(a);
    endfunction

    task automatic compare_step();
        logic [2:0]  dack, e_ack;
        logic [18:0] e_addr;
        logic [7:0]  e_rd;
        bit          in_txn, strobe, idle;
        int          d, w;
        dack = {ack2, ack1, ack0};
        if (!rst_n) begin
            m_act = 0; m_last_addr = '0; m_last_rd = '0; m_rr = 1; m_vb = 0; cyc = 0;
            chk("rst addr", 32'(mem_addr), 32'h0);
            chk("rst we", 32'(we_n), 32'h1);
            chk("rst oe", 32'(oe_n), 32'h1);
            chk("rst ack", 32'(dack), 32'h0);
            chk("rst rdata", 32'(rdata), 32'h0);
            chk_undriven("rst bus");
            return;
        end
        d      = m_act ? cyc - m_g : 0;
        in_txn = m_act && d >= 1 && d <= ACC + 2;
        strobe = in_txn && d >= 2 && d <= ACC + 1;
        e_addr = in_txn ? m_ta : m_last_addr;
        e_ack  = (in_txn && d == ACC + 2) ? 3'(1 << m_port) : 3'b000;
        e_rd   = (in_txn && d == ACC + 2 && !m_wr) ? m_trd : m_last_rd;
        chk("addr", 32'(mem_addr), 32'(e_addr));
        chk("we", 32'(we_n), 32'(!(strobe && m_wr)));
        chk("oe", 32'(oe_n), 32'(!(strobe && !m_wr)));
        chk("ack", 32'(dack), 32'(e_ack));
        chk("rdata", 32'(rdata), 32'(e_rd));
        if (in_txn && m_wr) chk("bus wr", 32'(mem_data), 32'(m_twd));
        else if (strobe) chk("bus rd", 32'(mem_data), 32'(m_trd));
        else chk_undriven("bus idle");
        if (dack != 3'b000) begin
            ack_cyc.push_back(cyc);
            ack_port.push_back(dack == 3'b001 ? 0 : dack == 3'b010 ? 1 : dack == 3'b100 ? 2 : 9);
        end
        if (in_txn && d == ACC + 2) begin
            if (m_wr) m_mem[m_ta] = m_twd;
            else m_last_rd = m_trd;
        end
        if (in_txn) m_last_addr = m_ta;
        idle = !m_act || d >= ACC + 3;
        if (idle) begin
            if (!(req[1] || req[2])) m_vb = 0;
            w = -1;
            if (req[0] && !(m_vb == MAXV && (req[1] || req[2]))) w = 0;
            else if (req[1] && req[2]) w = m_rr;
            else if (req[1]) w = 1;
            else if (req[2]) w = 2;
            if (w == 0 && (req[1] || req[2])) m_vb = (m_vb < MAXV) ? m_vb + 1 : MAXV;
            if (w > 0) begin
                m_vb = 0;
                m_rr = (w == 1) ? 2 : 1;
            end
            if (w >= 0) begin
                m_act = 1; m_g = cyc; m_port = w;
                m_wr = wr[w]; m_ta = addr[w]; m_twd = wd[w];
                m_trd = m_read(addr[w]);
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        for (int p = 0; p < 3; p++) begin
            req[p] = 1'b0; addr[p] = '0; wr[p] = 1'b0; wd[p] = 8'h01;
        end
    endtask

    task automatic enter_reset();
        tick();
        rst_n = 1'b0;
        clear_reqs();
        tick();
        tick();
    endtask

    // Caller sets cycle-0 requests first; this cycle becomes cycle 0
    task automatic release_reset();
        rst_n = 1'b1;
        ack_cyc.delete();
        ack_port.delete();
    endtask

    initial begin
        clear_reqs();
        fork
            forever begin
                @(negedge clk);
                compare_step();
            end
            forever begin
                @(posedge we_n);
                if (rst_n === 1'b1) sram[mem_addr] = mem_data;
            end
        join_none

        // 1: video read
        sram[19'h12345]  = 8'hA5;
        m_mem[19'h12345] = 8'hA5;
        enter_reset();
        req[0] = 1'b1; addr[0] = 19'h12345; wr[0] = 1'b0;
        release_reset();
        tick(); req[0] = 1'b0;
        chk("t1 addr c1", 32'(mem_addr), 32'h12345);
        chk("t1 oe c1", 32'(oe_n), 32'h1);
        tick(); chk("t1 oe c2", 32'(oe_n), 32'h0);
        tick(); chk("t1 oe c3", 32'(oe_n), 32'h0);
        chk("t1 we c3", 32'(we_n), 32'h1);
        tick(); chk("t1 ack0 c4", 32'(ack0), 32'h1);
        chk("t1 rdata c4", 32'(rdata), 32'hA5);
        tick(); chk("t1 ack0 c5", 32'(ack0), 32'h0);

        // 2: port 1 write
        enter_reset();
        req[1] = 1'b1; addr[1] = 19'h00010; wr[1] = 1'b1; wd[1] = 8'h3C;
        release_reset();
        tick(); req[1] = 1'b0;
        chk("t2 bus c1", 32'(mem_data), 32'h3C);
        chk("t2 we c1", 32'(we_n), 32'h1);
        tick(); chk("t2 we c2", 32'(we_n), 32'h0);
        tick(); chk("t2 we c3", 32'(we_n), 32'h0);
        tick(); chk("t2 ack1 c4", 32'(ack1), 32'h1);
        chk("t2 bus c4", 32'(mem_data), 32'h3C);
        tick(); chk_undriven("t2 bus c5");
        chk("t2 sram", 32'(sram.exists(19'h10) ? sram[19'h10] : 8'h00), 32'h3C);

        // 3: two general ports alternate
        enter_reset();
        req[1] = 1'b1; addr[1] = 19'h40001;
        req[2] = 1'b1; addr[2] = 19'h40002;
        release_reset();
        for (int i = 0; i < 60 && ack_port.size() < 4; i++) tick();
        chk("t3 ack count", 32'(ack_port.size() >= 4), 32'h1);
        if (ack_port.size() >= 4) begin
            chk("t3 first ack cycle", 32'(ack_cyc[0]), 32'd4);
            for (int i = 0; i < 4; i++) chk("t3 port", 32'(ack_port[i]), 32'(1 + (i % 2)));
            for (int i = 1; i < 4; i++) chk("t3 spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd5);
        end

        // 4: video burst limited by the starvation guard
        enter_reset();
        req[0] = 1'b1; addr[0] = 19'h40003;
        req[1] = 1'b1; addr[1] = 19'h40004;
        release_reset();
        for (int i = 0; i < 120 && ack_port.size() < 10; i++) tick();
        chk("t4 ack count", 32'(ack_port.size() >= 10), 32'h1);
        if (ack_port.size() >= 10) begin
            for (int i = 0; i < 10; i++) chk("t4 port", 32'(ack_port[i]), 32'((i % 5 == 4) ? 1 : 0));
        end

        // 5: reset in the middle of a write access
        enter_reset();
        req[2] = 1'b1; addr[2] = 19'h00020; wr[2] = 1'b1; wd[2] = 8'h77;
        release_reset();
        tick(); req[2] = 1'b0;
        tick();
        chk("t5 we before", 32'(we_n), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5 we async", 32'(we_n), 32'h1);
        chk("t5 oe async", 32'(oe_n), 32'h1);
        chk_undriven("t5 bus async");
        tick(); tick();
        req[1] = 1'b1; addr[1] = 19'h12345; wr[1] = 1'b0;
        release_reset();
        tick(); req[1] = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("t5 acks after", 32'(ack_port.size()), 32'd1);
        if (ack_port.size() == 1) begin
            chk("t5 port", 32'(ack_port[0]), 32'd1);
            chk("t5 cycle", 32'(ack_cyc[0]), 32'd4);
        end
        chk("t5 rdata", 32'(rdata), 32'hA5);

        // 6: request withdrawn and address changed after grant
        enter_reset();
        req[2] = 1'b1; addr[2] = 19'h40007; wr[2] = 1'b0;
        release_reset();
        tick(); req[2] = 1'b0; addr[2] = 19'h40008;
        tick(); tick();
        chk("t6 addr c3", 32'(mem_addr), 32'h40007);
        tick(); chk("t6 ack2 c4", 32'(ack2), 32'h1);
        chk("t6 rdata", 32'(rdata), 32'(mem_init(19'h40007)));
        for (int i = 0; i < 10; i++) tick();
        chk("t6 ack total", 32'(ack_port.size()), 32'd1);

        // Random traffic
        enter_reset();
        release_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [2:0] a;
            a = {ack2, ack1, ack0};
            for (int p = 0; p < 3; p++) begin
                if (!req[p] || a[p]) begin
                    if ($urandom_range(0, 3) == 0 || (req[p] && $urandom_range(0, 1) == 0)) begin
                        req[p]  = 1'b1;
                        addr[p] = 19'h40000 | 19'($urandom_range(0, 15));
                        wr[p]   = 1'($urandom_range(0, 1));
                        wd[p]   = 8'($urandom_range(1, 255));
                    end else if (a[p]) begin
                        req[p] = 1'b0;
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    req[p] = 1'b0;
                end
            end
            tick();
        end
        clear_reqs();
        for (int i = 0; i < 10; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
